// File: rtl/clk_interval_pkg.sv
// Package: clk_interval_pkg
// Shared definitions for clk_interval_gen: FSM state encoding, the LFSR
// feedback polynomial taps and the default LFSR seed.
package clk_interval_pkg;

  // Sequencer states. The name of each state matches what the strobe
  // outputs show in that cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, shift-left Fibonacci form:
  // feedback = bit15 ^ bit13 ^ bit12 ^ bit10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/clk_interval_gen_if.sv
// Interface: clk_interval_gen_if
// Groups the configuration, control and strobe/status signals of
// clk_interval_gen.
//   master : drives cfg_interval, cfg_gap, cfg_count, go, abort;
//            observes start_o, stop_o, busy, done, sent_cnt, cur_interval,
//            state_dbg
//   slave  : the generator itself (directions reversed)
// Control handshake: go is a single-cycle request with no ready signal; it
// is accepted only when the generator is idle (busy low) and abort is low.
// abort needs no acknowledge and takes effect at the next clock edge.
// state_dbg exposes the sequencer state for checkers.
interface clk_interval_gen_if #(
  parameter int CW = 32,
  parameter int NW = 16
);
  logic [CW-1:0]           cfg_interval;
  logic [CW-1:0]           cfg_gap;
  logic [NW-1:0]           cfg_count;
  logic                    go;
  logic                    abort;
  logic                    start_o;
  logic                    stop_o;
  logic                    busy;
  logic                    done;
  logic [NW-1:0]           sent_cnt;
  logic [CW-1:0]           cur_interval;
  clk_interval_pkg::state_t state_dbg;

  modport master (
    output cfg_interval, cfg_gap, cfg_count, go, abort,
    input  start_o, stop_o, busy, done, sent_cnt, cur_interval, state_dbg
  );

  modport slave (
    input  cfg_interval, cfg_gap, cfg_count, go, abort,
    output start_o, stop_o, busy, done, sent_cnt, cur_interval, state_dbg
  );
endinterface

// File: rtl/clk_interval_lfsr.sv
// Module: clk_interval_lfsr
// 16-bit Fibonacci LFSR supplying interval jitter. Advances by one step on
// each cycle en is high; jit is the low JW bits of the current state.
// Ports:
//   clk      in  clock
//   reset_n  in  asynchronous active-low reset (state <= SEED)
//   en       in  advance one step at this edge
//   jit      out JW-bit jitter value (current state, before advancing)
module clk_interval_lfsr
  import clk_interval_pkg::*;
#(
  parameter int          JW   = 4,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic [JW-1:0] jit
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb  = ^(lfsr_q & LFSR_TAPS);
  assign jit = lfsr_q[JW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

endmodule

// File: rtl/clk_interval_gen.sv
// Module: clk_interval_gen
// Transmit side of a start/stop cycle-measurement link. On go it emits a
// 1-cycle start strobe, then a 1-cycle stop strobe exactly N cycles later,
// waits G cycles, and repeats for cfg_count pairs (0 = until abort).
// Ports:
//   clk      in  single clock, posedge
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of clk_interval_gen_if (cfg_interval, cfg_gap,
//            cfg_count, go, abort in; start_o, stop_o, busy, done,
//            sent_cnt, cur_interval, state_dbg out)
// Optional feature macro: CLK_INTERVAL_GEN_JITTER_EN adds LFSR jitter of
// JW bits to N (saturating); without it N = max(cfg_interval,1).
module clk_interval_gen
  import clk_interval_pkg::*;
#(
  parameter int          CW   = 32,
  parameter int          NW   = 16,
  parameter int          JW   = 4,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               reset_n,
  clk_interval_gen_if.slave  bus
);

  state_t        state_q;
  logic          start_q, stop_q, busy_q, done_q;
  logic [NW-1:0] sent_q, count_q, sent_nxt;
  logic [CW-1:0] cur_q, n_base_q, g_q, cnt_q;
  logic [CW-1:0] n_src, n_eff;
  logic          last_pair, cnt_one;

  function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
    return (v == '0) ? CW'(1) : v;
  endfunction

  assign sent_nxt  = sent_q + NW'(1);
  // A finite run ends when the pair whose stop is showing now is the last.
  assign last_pair = (count_q != '0) && (sent_nxt == count_q);
  assign cnt_one   = (cnt_q == CW'(1));
  // The interval for a new pair comes straight from config at go, and from
  // the latched copy for every later pair of the run.
  assign n_src     = (state_q == S_IDLE) ? at_least_one(bus.cfg_interval) : n_base_q;

`ifdef CLK_INTERVAL_GEN_JITTER_EN
  logic          start_evt;
  logic [JW-1:0] jit;
  logic [CW:0]   n_sum;

  // Mirrors every branch of the FSM below that raises start_q.
  always_comb begin
    start_evt = 1'b0;
    if (!bus.abort) begin
      if (state_q == S_IDLE)
        start_evt = bus.go;
      else if ((state_q == S_GAP) || (state_q == S_STOP && !last_pair))
        start_evt = cnt_one;
    end
  end

  clk_interval_lfsr #(
    .JW   (JW),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (start_evt),
    .jit     (jit)
  );

  assign n_sum = {1'b0, n_src} + (CW+1)'(jit);
  assign n_eff = n_sum[CW] ? '1 : n_sum[CW-1:0];
`else
  localparam int          unused_jw   = JW;
  localparam logic [15:0] unused_seed = SEED;
  assign n_eff = n_src;
`endif

  // cnt_q holds the number of cycles left until the next strobe, counting
  // the current cycle; the strobe is launched at the edge where it reads 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sent_q   <= '0;
      count_q  <= '0;
      cur_q    <= '0;
      n_base_q <= '0;
      g_q      <= '0;
      cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.go) begin
              n_base_q <= at_least_one(bus.cfg_interval);
              g_q      <= at_least_one(bus.cfg_gap);
              count_q  <= bus.cfg_count;
              sent_q   <= '0;
              busy_q   <= 1'b1;
              start_q  <= 1'b1;
              cnt_q    <= n_eff;
              cur_q    <= n_eff;
              state_q  <= S_START;
            end
          end
          S_START, S_WAIT: begin
            if (cnt_one) begin
              stop_q  <= 1'b1;
              cnt_q   <= g_q;
              state_q <= S_STOP;
            end else begin
              cnt_q   <= cnt_q - CW'(1);
              state_q <= S_WAIT;
            end
          end
          S_STOP: begin
            sent_q <= sent_nxt;
            if (last_pair) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (cnt_one) begin
              start_q <= 1'b1;
              cnt_q   <= n_eff;
              cur_q   <= n_eff;
              state_q <= S_START;
            end else begin
              cnt_q   <= cnt_q - CW'(1);
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt_one) begin
              start_q <= 1'b1;
              cnt_q   <= n_eff;
              cur_q   <= n_eff;
              state_q <= S_START;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.start_o      = start_q;
  assign bus.stop_o       = stop_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sent_cnt     = sent_q;
  assign bus.cur_interval = cur_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_clk_interval_gen.sv
// Testbench: tb_clk_interval_gen
// Directed scenarios for clk_interval_gen. Events are logged per cycle as
// cycle*4 + kind (1 = start_o, 2 = stop_o, 3 = done), with cycle 0 being
// the cycle in which go is presented, and compared against hand-computed
// expected queues.
module tb_clk_interval_gen;
  import clk_interval_pkg::*;

  localparam int CW = 32;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] evt_q[$];
  logic [31:0] exp_q[$];
  logic        both_seen;
  logic [63:0] busy_log;

  clk_interval_gen_if #(.CW(CW), .NW(NW)) bus ();

  clk_interval_gen #(.CW(CW), .NW(NW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ev(input int c, input int k);
    return 32'(c * 4 + k);
  endfunction

  task automatic set_cfg(input logic [CW-1:0] iv, input logic [CW-1:0] gp,
                         input logic [NW-1:0] cn);
    bus.cfg_interval = iv;
    bus.cfg_gap      = gp;
    bus.cfg_count    = cn;
  endtask

  // Presents go for one cycle (cycle 0) and logs cycles 1..ncyc.
  // abort_after: raise abort after sampling that cycle (0 = never).
  // go_at: raise go again and change cfg_interval after sampling that cycle.
  task automatic run_trace(input int ncyc, input int abort_after, input int go_at);
    evt_q.delete();
    both_seen = 1'b0;
    busy_log  = '0;
    @(negedge clk);
    bus.go = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.go    = 1'b0;
      bus.abort = 1'b0;
      if (bus.start_o) evt_q.push_back(ev(c, 1));
      if (bus.stop_o)  evt_q.push_back(ev(c, 2));
      if (bus.done)    evt_q.push_back(ev(c, 3));
      if (bus.start_o && bus.stop_o) both_seen = 1'b1;
      busy_log[c] = bus.busy;
      if (c == abort_after) bus.abort = 1'b1;
      if (c == go_at) begin
        bus.go           = 1'b1;
        bus.cfg_interval = 32'd9;
      end
    end
  endtask

  task automatic test_reset;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    set_cfg(32'd0, 32'd0, 16'd0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.start_o, bus.stop_o, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000",
               {bus.start_o, bus.stop_o, bus.busy, bus.done});
    end
    n_checks++;
    if ({bus.sent_cnt, bus.cur_interval} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_counts: sent_cnt %0d cur_interval %0d required 0 0",
               bus.sent_cnt, bus.cur_interval);
    end
    n_checks++;
    if (bus.state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", bus.state_dbg, S_IDLE);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    set_cfg(32'd5, 32'd3, 16'd2);
    run_trace(20, 0, 0);
    exp_q.delete();
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(6, 2));
    exp_q.push_back(ev(9, 1));
    exp_q.push_back(ev(14, 2));
    exp_q.push_back(ev(15, 3));
    n_checks++;
    if (evt_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_evt_count: got %0d required %0d", evt_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= evt_q.size() || evt_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_evt[%0d]: got %0d required %0d (cycle*4+kind)",
                 i, (i < evt_q.size()) ? evt_q[i] : 32'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (busy_log[15:0] !== 16'h7FFE) begin
      n_fail++;
      $display("FAIL basic_busy: got %h required 7ffe", busy_log[15:0]);
    end
    n_checks++;
    if (bus.sent_cnt !== 16'd2 || bus.cur_interval !== 32'd5) begin
      n_fail++;
      $display("FAIL basic_counts: sent_cnt %0d cur_interval %0d required 2 5",
               bus.sent_cnt, bus.cur_interval);
    end
    n_checks++;
    if (both_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_overlap: start_o and stop_o high together");
    end
  endtask

  task automatic test_min_values;
    set_cfg(32'd0, 32'd0, 16'd3);
    run_trace(12, 0, 0);
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(ev(1 + 2 * p, 1));
      exp_q.push_back(ev(2 + 2 * p, 2));
    end
    exp_q.push_back(ev(7, 3));
    n_checks++;
    if (evt_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL min_evt_count: got %0d required %0d", evt_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= evt_q.size() || evt_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL min_evt[%0d]: got %0d required %0d (cycle*4+kind)",
                 i, (i < evt_q.size()) ? evt_q[i] : 32'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (busy_log[11:0] !== 12'h07E) begin
      n_fail++;
      $display("FAIL min_busy: got %h required 07e", busy_log[11:0]);
    end
    n_checks++;
    if (bus.sent_cnt !== 16'd3 || bus.cur_interval !== 32'd1) begin
      n_fail++;
      $display("FAIL min_counts: sent_cnt %0d cur_interval %0d required 3 1",
               bus.sent_cnt, bus.cur_interval);
    end
  endtask

  task automatic test_continuous_abort;
    set_cfg(32'd3, 32'd2, 16'd0);
    run_trace(20, 12, 0);
    exp_q.delete();
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(4, 2));
    exp_q.push_back(ev(6, 1));
    exp_q.push_back(ev(9, 2));
    exp_q.push_back(ev(11, 1));
    n_checks++;
    if (evt_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL abort_evt_count: got %0d required %0d", evt_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= evt_q.size() || evt_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_evt[%0d]: got %0d required %0d (cycle*4+kind)",
                 i, (i < evt_q.size()) ? evt_q[i] : 32'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (busy_log[20:0] !== 21'h001FFE) begin
      n_fail++;
      $display("FAIL abort_busy: got %h required 001ffe", busy_log[20:0]);
    end
    n_checks++;
    if (bus.sent_cnt !== 16'd2 || bus.state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL abort_hold: sent_cnt %0d state %0d required 2 %0d",
               bus.sent_cnt, bus.state_dbg, S_IDLE);
    end
  endtask

  task automatic test_ignore;
    set_cfg(32'd4, 32'd2, 16'd1);
    run_trace(10, 0, 2);
    exp_q.delete();
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(5, 2));
    exp_q.push_back(ev(6, 3));
    n_checks++;
    if (evt_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ignore_evt_count: got %0d required %0d", evt_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= evt_q.size() || evt_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ignore_evt[%0d]: got %0d required %0d (cycle*4+kind)",
                 i, (i < evt_q.size()) ? evt_q[i] : 32'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (busy_log[9:0] !== 10'h03E) begin
      n_fail++;
      $display("FAIL ignore_busy: got %h required 03e", busy_log[9:0]);
    end
    // go together with abort while idle
    bus.go    = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.start_o, bus.busy, bus.done} !== 3'b000 || bus.state_dbg !== S_IDLE) begin
      n_fail++;
      $display("FAIL go_abort_idle: start/busy/done %b state %0d required 000 %0d",
               {bus.start_o, bus.busy, bus.done}, bus.state_dbg, S_IDLE);
    end
    n_checks++;
    if (bus.sent_cnt !== 16'd1 || bus.cur_interval !== 32'd4) begin
      n_fail++;
      $display("FAIL go_abort_hold: sent_cnt %0d cur_interval %0d required 1 4",
               bus.sent_cnt, bus.cur_interval);
    end
  endtask

  task automatic test_reset_mid;
    set_cfg(32'd6, 32'd1, 16'd1);
    @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    n_checks++;
    if (bus.start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_start: got %b required 1", bus.start_o);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.start_o, bus.stop_o, bus.busy, bus.done, bus.sent_cnt, bus.cur_interval} !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: busy %b cur_interval %0d required all zero",
               bus.busy, bus.cur_interval);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_cfg(32'd2, 32'd1, 16'd1);
    run_trace(6, 0, 0);
    exp_q.delete();
    exp_q.push_back(ev(1, 1));
    exp_q.push_back(ev(3, 2));
    exp_q.push_back(ev(4, 3));
    n_checks++;
    if (evt_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL rmid_evt_count: got %0d required %0d", evt_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= evt_q.size() || evt_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rmid_evt[%0d]: got %0d required %0d (cycle*4+kind)",
                 i, (i < evt_q.size()) ? evt_q[i] : 32'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (bus.sent_cnt !== 16'd1 || bus.cur_interval !== 32'd2) begin
      n_fail++;
      $display("FAIL rmid_counts: sent_cnt %0d cur_interval %0d required 1 2",
               bus.sent_cnt, bus.cur_interval);
    end
  endtask

`ifdef CLK_INTERVAL_GEN_JITTER_EN
  task automatic test_jitter;
    logic [15:0] m;
    logic [31:0] exp_n;
    int          pairs;
    int          s_cyc;
    bit          done_seen;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    set_cfg(32'd10, 32'd1, 16'd100);
    m = 16'hACE1;
    exp_n = 32'd0;
    pairs = 0;
    s_cyc = 0;
    done_seen = 1'b0;
    @(negedge clk);
    bus.go = 1'b1;
    for (int c = 1; c <= 4000 && !done_seen; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (bus.start_o) begin
        s_cyc = c;
        exp_n = 32'd10 + 32'(m[3:0]);
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        n_checks++;
        if (bus.cur_interval !== exp_n) begin
          n_fail++;
          $display("FAIL jit_cur[%0d]: got %0d required %0d", pairs, bus.cur_interval, exp_n);
        end
      end
      if (bus.stop_o) begin
        n_checks++;
        if (32'(c - s_cyc) !== exp_n) begin
          n_fail++;
          $display("FAIL jit_dist[%0d]: got %0d required %0d", pairs, c - s_cyc, exp_n);
        end
        pairs++;
      end
      if (bus.done) done_seen = 1'b1;
    end
    n_checks++;
    if (pairs != 100 || !done_seen) begin
      n_fail++;
      $display("FAIL jit_run: pairs %0d done %b required 100 1", pairs, done_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_min_values();
    test_continuous_abort();
    test_ignore();
    test_reset_mid();
`ifdef CLK_INTERVAL_GEN_JITTER_EN
    test_jitter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
